// File: rtl/uart_rx_fsm.sv
// UART receive state machine: synchronises RX, finds the start edge, samples each
// bit at its mid-point and strobes the finished character with its error flags.
module uart_rx_fsm #(
    parameter int clk_divisor = 104,
    parameter int rx_num_bits = 8,
    parameter int parity      = 0
) (
    input  logic       clk,
    input  logic       RSTn,
    input  logic       RX,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int              CW         = $clog2(clk_divisor);
    localparam logic [CW-1:0]   HALF_LAST  = CW'(clk_divisor / 2 - 1);
    localparam logic [CW-1:0]   BIT_LAST   = CW'(clk_divisor - 1);
    localparam logic [2:0]      DATA_LAST  = 3'(rx_num_bits - 1);
    localparam logic            HAS_PARITY = (parity != 0);
    localparam logic            ODD_PARITY = (parity == 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Unused upper data bits are held at 0, so they never disturb the XOR.
    function automatic logic parity_mismatch(input logic [7:0] data,
                                             input logic       pbit,
                                             input logic       odd);
        return (((^data) ^ pbit) != odd);
    endfunction

    logic          sync1_q;
    logic          rx_s_q;
    logic          rx_prev_q;
    state_t        state_q,      state_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic [2:0]    bit_q,        bit_d;
    logic [7:0]    shift_q,      shift_d;
    logic          perr_pend_q,  perr_pend_d;
    logic [7:0]    data_out_q,   data_out_d;
    logic          valid_q,      valid_d;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q,  frame_err_d;
    logic          busy_q,       busy_d;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!RSTn) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= RX;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        bit_d        = bit_q;
        shift_d      = shift_q;
        perr_pend_d  = perr_pend_q;
        data_out_d   = data_out_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Only a high-to-low transition starts a frame; a held-low line is ignored.
                if (!rx_s_q && rx_prev_q) begin
                    state_d     = START;
                    bit_d       = 3'd0;
                    shift_d     = 8'h00;
                    perr_pend_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rx_s_q;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = 3'd0;
                        state_d = HAS_PARITY ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d       = '0;
                    perr_pend_d = parity_mismatch(shift_q, rx_s_q, ODD_PARITY);
                    state_d     = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d        = '0;
                    data_out_d   = shift_q;
                    parity_err_d = HAS_PARITY ? perr_pend_q : 1'b0;
                    frame_err_d  = !rx_s_q;
                    valid_d      = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!RSTn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'h00;
            perr_pend_q  <= 1'b0;
            data_out_q   <= 8'h00;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            perr_pend_q  <= perr_pend_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: three instances (no / even / odd parity) driven with directed
// and random frames; expected strobes come from the frame-timing rules.
module tb_uart_rx_fsm;

    localparam int D = 16;
    localparam int N = 8;
    localparam int H = D / 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rx   [3];
    logic [7:0] dout [3];
    logic       dv   [3];
    logic       pe   [3];
    logic       fe   [3];
    logic       bsy  [3];

    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail   = 0;

    typedef struct {
        int         dut;
        longint     cyc;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;
    exp_t expq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_rx_fsm #(.clk_divisor(D), .rx_num_bits(N), .parity(g)) dut (
            .clk        (clk),
            .RSTn       (rstn),
            .RX         (rx[g]),
            .data_out   (dout[g]),
            .data_valid (dv[g]),
            .parity_err (pe[g]),
            .frame_err  (fe[g]),
            .busy       (bsy[g])
        );
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Every strobe must match the oldest outstanding expected frame.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (dv[i] !== 1'b0) begin
                if (expq.size() == 0) begin
                    check_eq("strobe_expected", 64'(expq.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check_eq("strobe_dut",   64'(i),     64'(e.dut));
                    check_eq("strobe_cycle", 64'(cyc),   64'(e.cyc));
                    check_eq("data_out",     64'(dout[i]), 64'(e.data));
                    check_eq("parity_err",   64'(pe[i]), 64'(e.perr));
                    check_eq("frame_err",    64'(fe[i]), 64'(e.ferr));
                end
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input longint c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input int d);
        check_eq("zero_data_out",   64'(dout[d]), 64'd0);
        check_eq("zero_data_valid", 64'(dv[d]),   64'd0);
        check_eq("zero_parity_err", 64'(pe[d]),   64'd0);
        check_eq("zero_frame_err",  64'(fe[d]),   64'd0);
        check_eq("zero_busy",       64'(bsy[d]),  64'd0);
    endtask

    // Called just after a rising edge; leaves the line at the stop-bit level.
    task automatic send_frame(input int d, input logic [7:0] data, input logic flip,
                              input logic stop, input int abort_bit);
        int     p;
        longint k;
        logic   pb;
        logic   xr;
        exp_t   e;
        p  = (d != 0) ? 1 : 0;
        k  = cyc;
        xr = 1'b0;
        for (int i = 0; i < N; i++) xr = xr ^ data[i];
        pb = xr ^ (d == 2) ^ flip;
        if (abort_bit < 0) begin
            e.dut  = d;
            e.cyc  = k + 2 + H + (N + 1 + p) * D + 1;
            e.data = data;
            e.perr = (p == 1) ? ((xr ^ pb) != (d == 2)) : 1'b0;
            e.ferr = !stop;
            expq.push_back(e);
        end
        rx[d] = 1'b0;
        hold(D);
        for (int i = 0; i < N; i++) begin
            if (i == abort_bit) begin
                hold(H);
                rstn  = 1'b0;
                rx[d] = 1'b1;
                hold(1);
                rstn  = 1'b1;
                check_all_zero(d);
                return;
            end
            rx[d] = data[i];
            hold(D);
        end
        if (p == 1) begin
            rx[d] = pb;
            hold(D);
        end
        rx[d] = stop;
        hold(D);
    endtask

    initial begin
        longint t;
        for (int i = 0; i < 3; i++) rx[i] = 1'b1;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) check_all_zero(i);
        hold(20);

        // Basic frame, then outputs must hold after the strobe.
        send_frame(0, 8'hA5, 1'b0, 1'b1, -1);
        hold(30);
        check_eq("hold_data_out", 64'(dout[0]), 64'hA5);
        check_eq("idle_busy",     64'(bsy[0]),  64'd0);

        // Even parity: good then bad parity bit.
        send_frame(1, 8'h03, 1'b0, 1'b1, -1);
        hold(10);
        send_frame(1, 8'h03, 1'b1, 1'b1, -1);
        hold(30);

        // Glitch: 4-cycle low pulse is rejected at the start-bit sample.
        rx[0] = 1'b0;
        t = cyc + 2;
        hold(4);
        rx[0] = 1'b1;
        wait_to(t + 1);
        check_eq("glitch_busy_rise", 64'(bsy[0]), 64'd1);
        wait_to(t + H);
        check_eq("glitch_busy_at_sample", 64'(bsy[0]), 64'd1);
        wait_to(t + H + 1);
        check_eq("glitch_busy_fall", 64'(bsy[0]), 64'd0);
        hold(30);

        // Framing error followed by a long low line.
        send_frame(0, 8'h5A, 1'b0, 1'b0, -1);
        hold(100);
        check_eq("break_no_busy", 64'(bsy[0]), 64'd0);
        rx[0] = 1'b1;
        hold(20);

        // Reset during data bit 4, then a clean frame.
        send_frame(0, 8'($urandom), 1'b0, 1'b1, 4);
        hold(20);
        send_frame(0, 8'h3C, 1'b0, 1'b1, -1);
        hold(20);

        // Back-to-back frames with no idle gap.
        send_frame(0, 8'h00, 1'b0, 1'b1, -1);
        send_frame(0, 8'hFF, 1'b0, 1'b1, -1);
        send_frame(0, 8'h81, 1'b0, 1'b1, -1);
        hold(30);

        // Random frames across all three parity modes.
        for (int n = 0; n < 60; n++) begin
            int   d;
            int   gap;
            logic stp;
            d   = int'($urandom_range(0, 2));
            stp = ($urandom_range(0, 4) != 0);
            gap = int'($urandom_range(0, 6));
            send_frame(d, 8'($urandom), ($urandom_range(0, 3) == 0), stp, -1);
            if (!stp) begin
                rx[d] = 1'b1;
                gap   = gap + 2;
            end
            hold(gap);
        end

        hold(300);
        check_eq("pending_strobes", 64'(expq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
